// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_unit
// Purpose  : ID-stage hazard detection for the pipelined ARM core. A
//            per-register countdown scoreboard tracks when each in-flight
//            result becomes forwardable. RAW and WAW hazards stall ID, and a
//            saturating counter records the number of stalled cycles.
// Ports    : clk         - rising-edge clock
//            rst         - asynchronous active-low reset
//            id_valid    - ID holds a valid instruction
//            id_src      - NUM_SRC packed source register indices
//            id_src_used - per-source enable
//            id_wb_en    - instruction writes id_dest
//            id_dest     - destination register
//            id_lat      - producer latency (0 -> 1, clamped to MAX_LAT)
//            flush       - cancels the ID instruction this cycle
//            stat_clr    - synchronous clear of stall_cnt
//            hazard      - combinational stall request to IF/ID
//            issue       - id_valid & ~hazard & ~flush
//            src_hazard  - per-source RAW flags
//            busy        - any scoreboard entry nonzero
//            stall_cnt   - saturating count of stalled cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_unit #(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned MAX_LAT     = 4,
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned NOFWD_EXTRA = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]     id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          id_wb_en,
  input  logic [REG_AW-1:0]             id_dest,
  input  logic [$clog2(MAX_LAT+1)-1:0]  id_lat,
  input  logic                          flush,
  input  logic                          stat_clr,
  output logic                          hazard,
  output logic                          issue,
  output logic [NUM_SRC-1:0]            src_hazard,
  output logic                          busy,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int c_LW   = $clog2(MAX_LAT + 1);
  localparam int c_CW   = $clog2(MAX_LAT + NOFWD_EXTRA + 1);
  localparam int c_NREG = 1 << REG_AW;

  localparam logic [c_LW-1:0] c_LAT_MAX   = c_LW'(MAX_LAT);
  // Without forwarding every result is only readable after writeback.
  localparam logic [c_CW-1:0] c_LAT_EXTRA = (FWD_EN != 0) ? '0 : c_CW'(NOFWD_EXTRA);

  logic [c_CW-1:0]  r_cnt [c_NREG];
  logic [CNT_W-1:0] r_stall_cnt;

  logic [c_LW-1:0]  w_lat;
  logic [c_CW-1:0]  w_leff;
  logic             w_waw;
  logic             w_wr;
  logic             w_busy;

  // Latency normalisation: 0 behaves like a single-cycle ALU result.
  always_comb begin
    w_lat = id_lat;
    if (id_lat == '0) begin
      w_lat = c_LW'(1);
    end else if (id_lat > c_LAT_MAX) begin
      w_lat = c_LAT_MAX;
    end
  end

  assign w_leff = c_CW'(w_lat) + c_LAT_EXTRA;

  // RAW: any pending count on a used source blocks the read.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] w_idx;
      assign w_idx          = id_src[gi*REG_AW +: REG_AW];
      assign src_hazard[gi] = id_valid & id_src_used[gi] & ~flush & (r_cnt[w_idx] != '0);
    end
  endgenerate

  // WAW: the younger write must land strictly after the older one, otherwise
  // the older result would overwrite it.
  assign w_waw  = id_valid & id_wb_en & ~flush & (r_cnt[id_dest] >= w_leff);

  assign hazard = (|src_hazard) | w_waw;
  assign issue  = id_valid & ~hazard & ~flush;
  assign w_wr   = issue & id_wb_en;

  always_comb begin
    w_busy = 1'b0;
    for (int r = 0; r < c_NREG; r++) begin
      w_busy = w_busy | (r_cnt[r] != '0);
    end
  end

  assign busy = w_busy;

  // Scoreboard: entries drain by one per cycle; a new issue reloads only its
  // own destination with Leff-1 so a dependent can issue Leff cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < c_NREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < c_NREG; r++) begin
        if (w_wr && (id_dest == REG_AW'(r))) begin
          r_cnt[r] <= w_leff - c_CW'(1);
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - c_CW'(1);
        end
      end
    end
  end

  // Stall statistic: clear wins over increment; saturates at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stat_clr) begin
      r_stall_cnt <= '0;
    end else if (hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard_unit
// Purpose  : Directed self-checking bench for hazard_scoreboard_unit. One
//            instance uses forwarding (default parameters); a second one runs
//            without forwarding and with a 4-bit statistic so saturation is
//            reachable quickly. Both share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [11:0] id_src;
  logic [2:0]  id_src_used;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic [2:0]  id_lat;
  logic        flush;
  logic        stat_clr;

  logic        hazard, issue, busy;
  logic [2:0]  src_hazard;
  logic [15:0] stall_cnt;

  logic        nf_hazard, nf_issue, nf_busy;
  logic [2:0]  nf_src_hazard;
  logic [3:0]  nf_stall_cnt;

  int checks;
  int errors;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_lat(id_lat), .flush(flush), .stat_clr(stat_clr),
    .hazard(hazard), .issue(issue), .src_hazard(src_hazard),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard_unit #(.FWD_EN(0), .NOFWD_EXTRA(2), .CNT_W(4)) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_lat(id_lat), .flush(flush), .stat_clr(stat_clr),
    .hazard(nf_hazard), .issue(nf_issue), .src_hazard(nf_src_hazard),
    .busy(nf_busy), .stall_cnt(nf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic set_idle();
    id_valid = 1'b0; id_src = '0; id_src_used = '0; id_wb_en = 1'b0;
    id_dest = '0; id_lat = '0; flush = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic drive(input logic wb, input logic [3:0] dest, input logic [2:0] lat,
                       input logic [11:0] src, input logic [2:0] used);
    id_valid = 1'b1; id_wb_en = wb; id_dest = dest; id_lat = lat;
    id_src = src; id_src_used = used; flush = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    set_idle();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
  endtask

  // Called one time unit after a rising edge; release lands mid-cycle.
  task automatic apply_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 4'd0, 3'd1, 12'h000, 3'b001);
    #3;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL reset_issue: got %b want 1", issue); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    checks++; if (nf_busy !== 1'b0) begin errors++; $display("FAIL reset_nf_busy: got %b want 0", nf_busy); end
    flush = 1'b1;
    #0.5;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_flush_issue: got %b want 0", issue); end
    rst = 1'b1;
    set_idle();
    step();
  endtask

  task automatic test_alu_chain();
    clear_stats();
    drive(1'b1, 4'd3, 3'd1, 12'h000, 3'b000);
    @(negedge clk);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL alu_prod_issue: got %b want 1", issue); end
    step();
    drive(1'b0, 4'd0, 3'd1, 12'h003, 3'b001);
    @(negedge clk);
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL alu_dep_hazard: got %b want 0", hazard); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL alu_dep_issue: got %b want 1", issue); end
    step();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL alu_stall_cnt: got %0d want 0", stall_cnt); end
    set_idle();
  endtask

  task automatic test_load_use();
    clear_stats();
    drive(1'b1, 4'd5, 3'd2, 12'h000, 3'b000);
    step();
    drive(1'b0, 4'd0, 3'd1, 12'h050, 3'b010);
    @(negedge clk);
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL ld_hazard: got %b want 1", hazard); end
    checks++; if (src_hazard !== 3'b010) begin errors++; $display("FAIL ld_src_hazard: got %b want 010", src_hazard); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL ld_stall_issue: got %b want 0", issue); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld_busy: got %b want 1", busy); end
    step();
    @(negedge clk);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL ld_issue: got %b want 1", issue); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld_busy_drained: got %b want 0", busy); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL ld_stall_cnt: got %0d want 1", stall_cnt); end
    step();
    set_idle();
  endtask

  task automatic test_multiply();
    clear_stats();
    drive(1'b1, 4'd7, 3'd4, 12'h000, 3'b000);
    step();
    drive(1'b0, 4'd0, 3'd1, 12'h700, 3'b100);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL mul_hazard c%0d: got %b want 1", k, hazard); end
      checks++; if (src_hazard !== 3'b100) begin errors++; $display("FAIL mul_src_hazard c%0d: got %b want 100", k, src_hazard); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy c%0d: got %b want 1", k, busy); end
      step();
    end
    @(negedge clk);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL mul_issue: got %b want 1", issue); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b want 0", busy); end
    step();
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL mul_stall_cnt: got %0d want 3", stall_cnt); end
    // Unused source with a matching index must not stall.
    drive(1'b1, 4'd7, 3'd4, 12'h000, 3'b000);
    step();
    drive(1'b0, 4'd0, 3'd1, 12'h700, 3'b000);
    @(negedge clk);
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL mul_unused_hazard: got %b want 0", hazard); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL mul_unused_issue: got %b want 1", issue); end
    step();
    set_idle();
    repeat (3) step();
  endtask

  task automatic test_waw();
    clear_stats();
    drive(1'b1, 4'd2, 3'd4, 12'h000, 3'b000);
    step();
    drive(1'b1, 4'd2, 3'd1, 12'h000, 3'b000);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL waw_hazard c%0d: got %b want 1", k, hazard); end
      checks++; if (src_hazard !== 3'b000) begin errors++; $display("FAIL waw_src c%0d: got %b want 000", k, src_hazard); end
      step();
    end
    @(negedge clk);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_issue: got %b want 1", issue); end
    step();
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL waw_stall_cnt: got %0d want 3", stall_cnt); end
    // Flush during a WAW stall: no stall, no issue, entry keeps draining.
    drive(1'b1, 4'd2, 3'd4, 12'h000, 3'b000);
    step();
    drive(1'b1, 4'd2, 3'd1, 12'h000, 3'b000);
    flush = 1'b1;
    @(negedge clk);
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush_hazard: got %b want 0", hazard); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL flush_issue: got %b want 0", issue); end
    step();
    // Entry should now be 2: a lat=2 write still collides, then clears.
    drive(1'b1, 4'd2, 3'd2, 12'h000, 3'b000);
    @(negedge clk);
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL flush_cnt2_hazard: got %b want 1", hazard); end
    step();
    @(negedge clk);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL flush_cnt1_issue: got %b want 1", issue); end
    step();
    set_idle();
    repeat (2) step();
  endtask

  task automatic test_nofwd();
    apply_reset();
    drive(1'b1, 4'd9, 3'd1, 12'h000, 3'b000);
    @(negedge clk);
    checks++; if (nf_issue !== 1'b1) begin errors++; $display("FAIL nf_prod_issue: got %b want 1", nf_issue); end
    step();
    drive(1'b0, 4'd0, 3'd1, 12'h009, 3'b001);
    @(negedge clk);
    checks++; if (nf_hazard !== 1'b1) begin errors++; $display("FAIL nf_hazard c1: got %b want 1", nf_hazard); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL fwd_hazard c1: got %b want 0", hazard); end
    step();
    @(negedge clk);
    checks++; if (nf_hazard !== 1'b1) begin errors++; $display("FAIL nf_hazard c2: got %b want 1", nf_hazard); end
    step();
    @(negedge clk);
    checks++; if (nf_issue !== 1'b1) begin errors++; $display("FAIL nf_dep_issue: got %b want 1", nf_issue); end
    step();
    checks++; if (nf_stall_cnt !== 4'd2) begin errors++; $display("FAIL nf_stall_cnt: got %0d want 2", nf_stall_cnt); end
    set_idle();
    repeat (3) step();
  endtask

  task automatic test_stats();
    apply_reset();
    // Self-dependent MUL: issue every 6th cycle, 5 stall cycles in between.
    drive(1'b1, 4'd1, 3'd4, 12'h001, 3'b001);
    repeat (24) step();
    checks++; if (nf_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach: got %0d want 15", nf_stall_cnt); end
    repeat (6) step();
    checks++; if (nf_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d want 15", nf_stall_cnt); end
    @(negedge clk);
    checks++; if (nf_issue !== 1'b1) begin errors++; $display("FAIL sat_c30_issue: got %b want 1", nf_issue); end
    step();
    stat_clr = 1'b1;
    @(negedge clk);
    checks++; if (nf_hazard !== 1'b1) begin errors++; $display("FAIL clr_c31_hazard: got %b want 1", nf_hazard); end
    step();
    stat_clr = 1'b0;
    checks++; if (nf_stall_cnt !== 4'd0) begin errors++; $display("FAIL clr_priority: got %0d want 0", nf_stall_cnt); end
    set_idle();
    step();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    drive(1'b1, 4'd7, 3'd4, 12'h000, 3'b000);
    step();
    drive(1'b0, 4'd0, 3'd1, 12'h007, 3'b001);
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL rmid_pre_hazard: got %b want 1", hazard); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rmid_hazard: got %b want 0", hazard); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL rmid_issue: got %b want 1", issue); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after: got %b want 0", busy); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL rmid_issue_next: got %b want 1", issue); end
    set_idle();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    set_idle();
    rst = 1'b0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_multiply();
    test_waw();
    test_nofwd();
    test_stats();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
